rvc_fetch_align: RTL and testbench
==================================

# rvc_fetch_align

Fetch alignment buffer between instruction memory and the IF/ID pipeline register. It accepts 32-bit word-aligned fetch words and holds them in a 4-entry halfword queue. It emits one aligned instruction per handshake: a zero-extended 16-bit compressed instruction, or a 32-bit instruction that may straddle two words. It tracks the PC of the instruction at the head and restarts cleanly on a branch or jump redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  redirect: discard all buffered state this cycle.
- flush_pc  in  32  new PC when flush=1; bit 0 ignored.
- word_valid  in  1  word_data/word_pc valid.
- word_ready  out  1  buffer accepts a word this cycle.
- word_data  in  32  fetched word; halfword 0 in [15:0].
- word_pc  in  32  word address; informational only, not checked.
- inst_valid  out  1  inst_data/inst_pc/inst_is_c valid.
- inst_ready  in  1  IF/ID register consumes the instruction.
- inst_data  out  32  instruction; compressed ones are zero-extended to [15:0].
- inst_pc  out  32  PC of inst_data.
- inst_is_c  out  1  1 = 16-bit instruction.

## Operation
- Storage: 4 halfword slots, occupancy count 0..4, head_pc register, drop_half flag.
- Push: when word_valid && word_ready, the word is accepted.
  - Normally, halfword 0 then halfword 1 are appended (count +2).
  - If drop_half=1, only halfword 1 is appended (count +1), then drop_half clears.
- word_ready = !rst && !flush && count <= 2. It depends on state and flush only, never on word_valid or inst_ready.
- Head classification: head halfword [1:0] != 2'b11 means compressed; otherwise 32-bit.
- inst_valid:
  - Compressed head: count >= 1.
  - 32-bit head: count >= 2.
- inst_data:
  - Compressed: {16'h0, head}.
  - 32-bit: {head+1, head}.
- Pop: when inst_valid && inst_ready:
  - remove 1 slot (compressed) or 2 slots (32-bit);
  - head_pc += 2 or 4.
- Simultaneous push and pop in one cycle are both allowed: count_next = count + push_len - pop_len.
- Flush has priority over push and pop:
  - count = 0 and head_pc = {flush_pc[31:1], 1'b0};
  - drop_half = flush_pc[1];
  - any word presented in the flush cycle is not accepted.
- Upstream is responsible for discarding stale in-flight words after a flush.
- inst_* are driven from registered state only. There is no combinational path from word_* or inst_ready to inst_*.
- While inst_valid=1 and inst_ready=0, inst_data, inst_pc and inst_is_c hold stable. A push does not change the head.

## Timing
- Reset state:
  - count=0, head_pc=RESET_PC, drop_half=0, all slots 0;
  - inst_valid=0, inst_data=0, inst_pc=RESET_PC, inst_is_c=0;
  - word_ready=0 while rst=1, and 1 in the first cycle after rst falls.
- A reset asserted mid-stream discards everything, identical to a power-on reset.
- Latency: a word accepted at edge N is visible on inst_* in cycle N+1. This requires the head instruction to be complete.
- Straddling 32-bit instruction: inst_valid rises in the cycle after the second word is accepted.
- Throughput: one instruction per cycle while words keep arriving.
- Full: count=3 or 4 forces word_ready=0. A pop in the same cycle does not raise word_ready.
- Empty: count=0, or count=1 with a 32-bit head, forces inst_valid=0.
- head_pc wraps modulo 2^32.

## Configuration
- RVC_EN defined: full behaviour as above.
- RVC_EN undefined:
  - every head is treated as 32-bit and inst_is_c ties to 0;
  - flush_pc[1] is ignored and drop_half is never set;
  - pop is always 2 slots and head_pc always advances by 4;
  - the interface is unchanged.

## Test plan
1. Reset, then words 0x00000013 @0 and 0x00100093 @4 with inst_ready=1 -> 0x00000013 @pc 0 and 0x00100093 @pc 4, is_c=0, one cycle after each accept.
2. Word 0x45014501 @0 -> 0x00004501 @pc 0 then 0x00004501 @pc 2, both is_c=1, in consecutive cycles.
3. Words 0x00134501 @0 and 0x45010000 @4 -> 0x00004501 @0 (c), 0x00000013 @2 (32-bit straddle), 0x00004501 @6 (c).
4. flush=1, flush_pc=0x102, then word 0x45010000 @0x100 -> single output 0x00004501 @pc 0x102, is_c=1; nothing emitted for 0x0000.
5. inst_ready=0 with words streaming -> word_ready drops once count>=3; inst_* stay stable. Raising inst_ready drains the buffer in order with no loss or duplication.
6. RVC_EN undefined, word 0x45014501 @0 -> one output 0x45014501 @pc 0, is_c=0; next inst_pc=4.

Source files
------------

// File: rtl/rvc_fetch_align.sv
`default_nettype none
// ============================================================================
// Module      : rvc_fetch_align
// Description : Fetch alignment buffer. Splits 32-bit fetch words into a
//               4-slot halfword queue and emits one aligned 16/32-bit
//               instruction per handshake. Compressed support under RVC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rvc_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [31:0] word_data,
    input  logic [31:0] word_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    logic [15:0] r_slot [4];
    logic [2:0]  r_count;
    logic [31:0] r_head_pc;
    logic        r_drop_half;

    logic        w_head_c;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_push_len;
    logic [2:0]  w_pop_len;
    logic [2:0]  w_base;
    logic [2:0]  w_count_next;
    logic [15:0] w_slot_next [4];
    logic        w_unused;

`ifdef RVC_EN
    assign w_head_c = (r_slot[0][1:0] != 2'b11);
`else
    assign w_head_c = 1'b0;
`endif

    // Outputs come only from registered state; a push never touches slot 0/1
    // of a waiting head, so a stalled instruction holds stable.
    assign inst_valid = w_head_c ? (r_count >= 3'd1) : (r_count >= 3'd2);
    assign inst_data  = w_head_c ? {16'h0000, r_slot[0]} : {r_slot[1], r_slot[0]};
    assign inst_pc    = r_head_pc;
    assign inst_is_c  = w_head_c && (r_count != 3'd0);

    assign word_ready = !rst && !flush && (r_count <= 3'd2);

    assign w_push       = word_valid && word_ready;
    assign w_pop        = inst_valid && inst_ready;
    assign w_pop_len    = !w_pop  ? 3'd0 : (w_head_c    ? 3'd1 : 3'd2);
    assign w_push_len   = !w_push ? 3'd0 : (r_drop_half ? 3'd1 : 3'd2);
    assign w_base       = r_count - w_pop_len;
    assign w_count_next = r_count + w_push_len - w_pop_len;

    assign w_unused = ^{word_pc, flush_pc[0]};

    // Shift out popped halfwords, then append the new ones behind the survivors.
    always_comb begin
        logic [2:0] w_src;
        w_src = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w_slot_next[i] = 16'h0000;
            w_src          = 3'(i) + w_pop_len;
            if (w_src < 3'd4) begin
                w_slot_next[i] = r_slot[w_src[1:0]];
            end
            if (w_push) begin
                if (r_drop_half) begin
                    if (3'(i) == w_base) begin
                        w_slot_next[i] = word_data[31:16];
                    end
                end else begin
                    if (3'(i) == w_base) begin
                        w_slot_next[i] = word_data[15:0];
                    end
                    if (3'(i) == w_base + 3'd1) begin
                        w_slot_next[i] = word_data[31:16];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 3'd0;
            r_head_pc   <= RESET_PC;
            r_drop_half <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= 16'h0000;
            end
        end else if (flush) begin
            r_count   <= 3'd0;
            r_head_pc <= {flush_pc[31:1], 1'b0};
`ifdef RVC_EN
            r_drop_half <= flush_pc[1];
`else
            r_drop_half <= 1'b0;
`endif
        end else begin
            r_count   <= w_count_next;
            r_head_pc <= r_head_pc + {28'd0, w_pop_len, 1'b0};
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= w_slot_next[i];
            end
            if (w_push) begin
                r_drop_half <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvc_fetch_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvc_fetch_align
// Description : Scoreboard bench for rvc_fetch_align; RVC_EN selects scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvc_fetch_align;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [31:0] word_data = 32'h0;
    logic [31:0] word_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q [$];
    logic [64:0] mon_e;

    rvc_fetch_align #(.RESET_PC(C_RESET_PC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .word_valid(word_valid), .word_ready(word_ready),
        .word_data(word_data), .word_pc(word_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_is_c(inst_is_c)
    );

    always #5 clk = ~clk;

    // Scoreboard: every consumed instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && !flush && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra got data=%h pc=%h c=%b required none", inst_data, inst_pc, inst_is_c);
            end else begin
                mon_e = exp_q.pop_front();
                if ({inst_data, inst_pc, inst_is_c} !== mon_e) begin
                    errors++;
                    $display("FAIL scoreboard got data=%h pc=%h c=%b required data=%h pc=%h c=%b",
                             inst_data, inst_pc, inst_is_c, mon_e[64:33], mon_e[32:1], mon_e[0]);
                end
            end
        end
    end

    task automatic expect_inst(input logic [31:0] d, input logic [31:0] pc, input logic c);
        exp_q.push_back({d, pc, c});
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        word_valid = 1'b1; word_data = d; word_pc = a;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (word_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout word=%h got word_ready=0 required 1", d);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic flush_to(input logic [31:0] p);
        @(posedge clk); #1;
        flush = 1'b1; flush_pc = p;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b required 0", word_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || inst_pc !== {p[31:1], 1'b0}) begin
            errors++;
            $display("FAIL flush_state got valid=%b pc=%h required valid=0 pc=%h", inst_valid, inst_pc, {p[31:1], 1'b0});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 ||
            inst_pc !== C_RESET_PC || inst_is_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b d=%h pc=%h c=%b required 0 0 0 %h 0",
                     word_ready, inst_valid, inst_data, inst_pc, inst_is_c, C_RESET_PC);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b v=%b required 1 0", word_ready, inst_valid);
        end
    endtask

    task automatic test_basic();
        inst_ready = 1'b1;
        expect_inst(32'h0000_0013, 32'h0, 1'b0);
        expect_inst(32'h0010_0093, 32'h4, 1'b0);
        send(32'h0000_0013, 32'h0);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_data !== 32'h0000_0013) begin
            errors++;
            $display("FAIL basic_latency0 got v=%b d=%h required 1 00000013", inst_valid, inst_data);
        end
        send(32'h0010_0093, 32'h4);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
            errors++;
            $display("FAIL basic_latency1 got v=%b pc=%h required 1 00000004", inst_valid, inst_pc);
        end
        drain();
    endtask

`ifdef RVC_EN
    task automatic test_compressed();
        inst_ready = 1'b1;
        flush_to(32'h0);
        expect_inst(32'h0000_4501, 32'h0, 1'b1);
        expect_inst(32'h0000_4501, 32'h2, 1'b1);
        send(32'h4501_4501, 32'h0);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_is_c !== 1'b1) begin
            errors++;
            $display("FAIL comp_first got v=%b pc=%h c=%b required 1 0 1", inst_valid, inst_pc, inst_is_c);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h2) begin
            errors++;
            $display("FAIL comp_second got v=%b pc=%h required 1 2", inst_valid, inst_pc);
        end
        drain();
    endtask

    task automatic test_straddle();
        inst_ready = 1'b1;
        flush_to(32'h0);
        expect_inst(32'h0000_4501, 32'h0, 1'b1);
        expect_inst(32'h0000_0013, 32'h2, 1'b0);
        expect_inst(32'h0000_4501, 32'h6, 1'b1);
        send(32'h0013_4501, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL straddle_half got v=%b required 0", inst_valid);
        end
        send(32'h4501_0000, 32'h4);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_data !== 32'h0000_0013 || inst_is_c !== 1'b0) begin
            errors++;
            $display("FAIL straddle_join got v=%b d=%h c=%b required 1 00000013 0", inst_valid, inst_data, inst_is_c);
        end
        drain();
    endtask

    task automatic test_flush_odd();
        inst_ready = 1'b1;
        flush_to(32'h0000_0102);
        expect_inst(32'h0000_4501, 32'h102, 1'b1);
        send(32'h4501_0000, 32'h100);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || inst_pc !== 32'h104) begin
            errors++;
            $display("FAIL flush_odd_after got v=%b pc=%h required 0 00000104", inst_valid, inst_pc);
        end
        drain();
    endtask

    task automatic test_full_odd();
        inst_ready = 1'b0;
        flush_to(32'h0000_0002);
        expect_inst(32'h0000_4501, 32'h2, 1'b1);
        expect_inst(32'h0000_0013, 32'h4, 1'b0);
        send(32'h4501_0000, 32'h0);
        send(32'h0000_0013, 32'h4);
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h2) begin
            errors++;
            $display("FAIL full3 got rdy=%b v=%b pc=%h required 0 1 2", word_ready, inst_valid, inst_pc);
        end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0) begin
            errors++;
            $display("FAIL full3_pop got rdy=%b required 0", word_ready);
        end
        drain();
    endtask
`else
    task automatic test_no_rvc();
        inst_ready = 1'b1;
        flush_to(32'h0);
        expect_inst(32'h4501_4501, 32'h0, 1'b0);
        send(32'h4501_4501, 32'h0);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || inst_is_c !== 1'b0 || inst_data !== 32'h4501_4501) begin
            errors++;
            $display("FAIL norvc_out got v=%b c=%b d=%h required 1 0 45014501", inst_valid, inst_is_c, inst_data);
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || inst_pc !== 32'h4) begin
            errors++;
            $display("FAIL norvc_next got v=%b pc=%h required 0 00000004", inst_valid, inst_pc);
        end
        drain();
    endtask
`endif

    task automatic test_backpressure();
        logic [31:0] w [4];
        int idx;
        bit acc;
        w[0] = 32'h0000_0013; w[1] = 32'h0010_0093;
        w[2] = 32'h0020_0113; w[3] = 32'h0030_0193;
        inst_ready = 1'b0;
        flush_to(32'h0);
        for (int i = 0; i < 4; i++) expect_inst(w[i], 32'(4 * i), 1'b0);
        idx = 0;
        @(posedge clk); #1;
        word_valid = 1'b1; word_data = w[0]; word_pc = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = (word_ready === 1'b1);
            if (idx > 0) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_data !== w[0] || inst_pc !== 32'h0 || inst_is_c !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_stable got v=%b d=%h pc=%h c=%b required 1 %h 0 0",
                             inst_valid, inst_data, inst_pc, inst_is_c, w[0]);
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin word_data = w[idx]; word_pc = 32'(4 * idx); end
                else word_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (idx != 2 || word_ready !== 1'b0) begin
            errors++;
            $display("FAIL full4 got accepted=%0d rdy=%b required 2 0", idx, word_ready);
        end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            acc = (word_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin word_data = w[idx]; word_pc = 32'(4 * idx); end
                else word_valid = 1'b0;
            end
        end
        word_valid = 1'b0;
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL resume got accepted=%0d required 4", idx);
        end
        drain();
    endtask

    task automatic test_wrap();
        inst_ready = 1'b1;
        flush_to(32'hFFFF_FFFC);
        expect_inst(32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
        send(32'h0000_0013, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap got %h required 00000000", inst_pc);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        inst_ready = 1'b0;
        flush_to(32'h40);
        send(32'h0000_0013, 32'h40);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got v=%b required 1", inst_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready got %b required 0", word_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || inst_pc !== C_RESET_PC || inst_data !== 32'h0 || inst_is_c !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got v=%b pc=%h d=%h c=%b required 0 %h 0 0",
                     inst_valid, inst_pc, inst_data, inst_is_c, C_RESET_PC);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release got rdy=%b v=%b required 1 0", word_ready, inst_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef RVC_EN
        test_compressed();
        test_straddle();
        test_flush_odd();
        test_full_odd();
`else
        test_no_rvc();
`endif
        test_backpressure();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
